// File: rtl/cnt_pkg.sv
// ----------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the cascaded digit counter.
//   digit_t      : default-width digit type (DIGIT_W_DEFAULT bits)
//   term_val()   : terminal digit value for a direction (MODULUS-1 up, 0 down)
//   clamp_digit(): folds an out-of-range digit down to MODULUS-1
// Optional feature macro used by the counter top: CNT_WRAP_TALLY_EN
// ----------------------------------------------------------------------------
package cnt_pkg;

  localparam int DIGIT_W_DEFAULT = 4;

  typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

  // Value at which a digit passes its enable on to the next stage.
  function automatic int term_val(input logic up, input int modulus);
    return up ? (modulus - 1) : 0;
  endfunction

  // Load values beyond the digit's range are pinned to the top state so a
  // digit can never hold an illegal code.
  function automatic int clamp_digit(input int v, input int modulus);
    return (v >= modulus) ? (modulus - 1) : v;
  endfunction

endpackage

// File: rtl/cnt_digit.sv
// ----------------------------------------------------------------------------
// cnt_digit
// One modulo-MODULUS up/down digit stage of the serial-carry counter.
// State updates on the falling edge of clock; reset is asynchronous active-high.
// Ports:
//   clock, reset : clock (falling edge active) and async clear
//   t_in         : toggle/step enable arriving from the previous stage
//   up           : 1 = count up, 0 = count down
//   load, ld_val : synchronous load (overrides t_in), value clamped to range
//   d            : current digit value
//   t_out        : enable for the next stage, t_in & (d == terminal)
// ----------------------------------------------------------------------------
module cnt_digit
  import cnt_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               t_in,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] d,
  output logic               t_out
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] d_q;
  logic [DIGIT_W-1:0] d_d;
  logic [DIGIT_W-1:0] term;

  // Terminal value follows the direction sampled on this edge.
  always_comb begin
    term = DIGIT_W'(term_val(up, MODULUS));
  end

  // Load wins over stepping; stepping wraps at the modulus boundary in
  // either direction.
  always_comb begin
    d_d = d_q;
    if (load) begin
      d_d = DIGIT_W'(clamp_digit(int'(ld_val), MODULUS));
    end else if (t_in) begin
      if (up) begin
        d_d = (d_q == MAX_D) ? '0 : d_q + 1'b1;
      end else begin
        d_d = (d_q == '0) ? MAX_D : d_q - 1'b1;
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign d     = d_q;
  assign t_out = t_in & (d_q == term);

endmodule

// File: rtl/cascade_digit_counter.sv
// ----------------------------------------------------------------------------
// cascade_digit_counter
// NDIGITS chained modulo-MODULUS digit stages with a ripple (serial) enable
// chain, up/down direction, synchronous clamped load and a combinational
// cascade carry/borrow output. All state changes on the falling clock edge.
// Ports:
//   clock    : counter clock, falling edge active
//   reset    : asynchronous active-high clear of all state
//   en       : count enable into digit 0
//   up       : 1 = count up, 0 = count down
//   load     : synchronous load of load_val (overrides en)
//   load_val : parallel load value, digit i at [i*DIGIT_W +: DIGIT_W]
//   q        : current count, digit 0 least significant
//   cout     : en & all digits terminal & ~load, for chaining into another en
//   wraps    : saturating wrap tally (only with CNT_WRAP_TALLY_EN)
// Optional feature macro: CNT_WRAP_TALLY_EN (adds TALLY_W and wraps).
// ----------------------------------------------------------------------------
module cascade_digit_counter
  import cnt_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 16,
  parameter int NDIGITS = 4
`ifdef CNT_WRAP_TALLY_EN
  ,
  parameter int TALLY_W = 16
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       up,
  input  logic                       load,
  input  logic [NDIGITS*DIGIT_W-1:0] load_val,
  output logic [NDIGITS*DIGIT_W-1:0] q,
  output logic                       cout
`ifdef CNT_WRAP_TALLY_EN
  ,
  output logic [TALLY_W-1:0]         wraps
`endif
);

  // t[i] is the step enable of digit i; t[NDIGITS] means every digit is at
  // its terminal value while enabled.
  logic [NDIGITS:0] t;

  assign t[0] = en;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    cnt_digit #(
      .DIGIT_W(DIGIT_W),
      .MODULUS(MODULUS)
    ) u_digit (
      .clock (clock),
      .reset (reset),
      .t_in  (t[i]),
      .up    (up),
      .load  (load),
      .ld_val(load_val[i*DIGIT_W +: DIGIT_W]),
      .d     (q[i*DIGIT_W +: DIGIT_W]),
      .t_out (t[i+1])
    );
  end

  // A load on the same edge discards the pending wrap, so no carry leaves.
  assign cout = t[NDIGITS] & ~load;

`ifdef CNT_WRAP_TALLY_EN
  logic [TALLY_W-1:0] wraps_q;
  logic [TALLY_W-1:0] wraps_d;

  // Count whole-counter wraps, sticking at all-ones instead of rolling over.
  always_comb begin
    wraps_d = wraps_q;
    if (cout && (wraps_q != '1)) begin
      wraps_d = wraps_q + 1'b1;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      wraps_q <= '0;
    end else begin
      wraps_q <= wraps_d;
    end
  end

  assign wraps = wraps_q;
`endif

endmodule

// File: tb/tb_cascade_digit_counter.sv
// ----------------------------------------------------------------------------
// tb_cascade_digit_counter
// Drives a hex instance (MODULUS 16, 4 digits) and a BCD instance (MODULUS 10,
// 3 digits) from shared inputs. Each counter is modelled as a single integer
// in base MODULUS; expected responses go into a queue that a separate monitor
// drains and compares. Wrap tally is compared when CNT_WRAP_TALLY_EN is set.
// ----------------------------------------------------------------------------
module tb_cascade_digit_counter;

  localparam int H_MOD = 16;
  localparam int H_ND  = 4;
  localparam int B_MOD = 10;
  localparam int B_ND  = 3;
  localparam int T_MAX = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] q_h;
  logic [11:0] q_b;
  logic        cout_h;
  logic        cout_b;
`ifdef CNT_WRAP_TALLY_EN
  logic [1:0]  wraps_h;
  logic [1:0]  wraps_b;
`endif

  cascade_digit_counter #(
    .DIGIT_W(4),
    .MODULUS(H_MOD),
    .NDIGITS(H_ND)
`ifdef CNT_WRAP_TALLY_EN
    ,
    .TALLY_W(2)
`endif
  ) dut_hex (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .q       (q_h),
    .cout    (cout_h)
`ifdef CNT_WRAP_TALLY_EN
    ,
    .wraps   (wraps_h)
`endif
  );

  cascade_digit_counter #(
    .DIGIT_W(4),
    .MODULUS(B_MOD),
    .NDIGITS(B_ND)
`ifdef CNT_WRAP_TALLY_EN
    ,
    .TALLY_W(2)
`endif
  ) dut_bcd (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val[11:0]),
    .q       (q_b),
    .cout    (cout_b)
`ifdef CNT_WRAP_TALLY_EN
    ,
    .wraps   (wraps_b)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        cout_h;
    logic [15:0] q_h;
    int          w_h;
    logic        cout_b;
    logic [11:0] q_b;
    int          w_b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   val_h = 0;
  int   val_b = 0;
  int   tally_h = 0;
  int   tally_b = 0;

  // Number of distinct counter states: MODULUS**NDIGITS.
  function automatic int span(input int m, input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * m;
    return p;
  endfunction

  // Integer count rendered as packed 4-bit digits.
  function automatic logic [15:0] to_q(input int v, input int m, input int n);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[i*4 +: 4] = 4'(x % m);
      x = x / m;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [15:0] lv, input int m, input int n);
    int r;
    int p;
    int dg;
    r = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      dg = int'(lv[i*4 +: 4]);
      if (dg >= m) dg = m - 1;
      r = r + dg * p;
      p = p * m;
    end
    return r;
  endfunction

  function automatic logic model_cout(input int v, input int m, input int n,
                                      input logic e, input logic u, input logic l);
    return e && !l && (v == (u ? span(m, n) - 1 : 0));
  endfunction

  function automatic int model_next(input int v, input int m, input int n,
                                    input logic e, input logic u, input logic l,
                                    input logic [15:0] lv);
    if (l) return load_value(lv, m, n);
    if (!e) return v;
    if (u) return (v + 1) % span(m, n);
    return (v + span(m, n) - 1) % span(m, n);
  endfunction

  function automatic int model_tally(input int w, input logic c);
    return (c && (w < T_MAX)) ? w + 1 : w;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One falling edge worth of stimulus; inputs change just after the rising
  // edge so they are stable well before the active falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [15:0] lv);
    exp_t        x;
    logic [15:0] tmp;
    @(posedge clock);
    #1;
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    if (r) begin
      val_h   = 0;
      val_b   = 0;
      tally_h = 0;
      tally_b = 0;
    end
    x.cout_h = model_cout(val_h, H_MOD, H_ND, e, u, l);
    x.cout_b = model_cout(val_b, B_MOD, B_ND, e, u, l);
    if (!r) begin
      tally_h = model_tally(tally_h, x.cout_h);
      tally_b = model_tally(tally_b, x.cout_b);
      val_h   = model_next(val_h, H_MOD, H_ND, e, u, l, lv);
      val_b   = model_next(val_b, B_MOD, B_ND, e, u, l, lv);
    end
    x.q_h = to_q(val_h, H_MOD, H_ND);
    tmp   = to_q(val_b, B_MOD, B_ND);
    x.q_b = tmp[11:0];
    x.w_h = tally_h;
    x.w_b = tally_b;
    sb.push_back(x);
    if (r) begin
      #1;
      checkOutput("async_reset_q_hex", int'(q_h), 0);
      checkOutput("async_reset_q_bcd", int'(q_b), 0);
`ifdef CNT_WRAP_TALLY_EN
      checkOutput("async_reset_wraps_hex", int'(wraps_h), 0);
      checkOutput("async_reset_wraps_bcd", int'(wraps_b), 0);
`endif
    end
  endtask

  // Monitor: cout is sampled while inputs are stable before the falling edge,
  // state is sampled just after it.
  initial begin
    logic ch;
    logic cb;
    exp_t x;
    forever begin
      @(posedge clock);
      #3;
      ch = cout_h;
      cb = cout_b;
      @(negedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput("cout_hex", int'(ch), int'(x.cout_h));
        checkOutput("cout_bcd", int'(cb), int'(x.cout_b));
        checkOutput("q_hex", int'(q_h), int'(x.q_h));
        checkOutput("q_bcd", int'(q_b), int'(x.q_b));
`ifdef CNT_WRAP_TALLY_EN
        checkOutput("wraps_hex", int'(wraps_h), x.w_h);
        checkOutput("wraps_bcd", int'(wraps_b), x.w_b);
`endif
      end
    end
  end

  initial begin
    logic        r;
    logic        e;
    logic        u;
    logic        l;
    logic [15:0] lv;
    reset    = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset held, a few counts, a reset pulse mid-count, then a full hex lap.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65536; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Decimal carry across digits and full BCD wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0099);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0999);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Down-count through zero.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Load beats enable, out-of-range digits clamp.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0F3A);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

    // Hold with en low, then flip direction every edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0009);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, i[0], 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Five forced wraps, reset pulse, then a load that must leave tally alone.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);

    // Randomised traffic, biased toward terminal values to provoke wraps.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 7) != 0);
      u = 1'(($urandom() >> 3) & 1);
      l = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 16'hFFFF;
        1:       lv = 16'h0000;
        2:       lv = 16'h0999;
        default: lv = 16'($urandom());
      endcase
      applyStimulus(r, e, u, l, lv);
    end

    repeat (3) @(posedge clock);
    checkOutput("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
